dac_multi_trig_gen: RTL and testbench

Parametrised DAC trigger generator. Each accepted trigger rising edge opens a programmable hold window, `trig_delay`. The block emits configurable-width pulses on `dac_multi_trig` at the window's opening and/or closing edge. It adds retrigger control, an enable gate, an overrun flag and an accepted-trigger counter, all in the `clk` domain. It sits between the timing/event decoder and the DAC sequencer.

---
 rtl/dac_trig_pkg.sv | 14 +
 rtl/trig_pulse_stretch.sv | 42 ++++
 rtl/dac_multi_trig_gen.sv | 133 +++++++++++++
 tb/tb_dac_multi_trig_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_trig_pkg.sv
// Shared constants for the DAC multi-trigger generator.
// Holds the edge_sel bit positions and the default field widths.
package dac_trig_pkg;

  // Bit positions inside edge_sel
  localparam int EDGE_OPEN  = 0;
  localparam int EDGE_CLOSE = 1;

  // Default widths: hold-window length/counter, pulse-width field, trigger counter
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_PW_W   = 4;
  localparam int DEF_TCNT_W = 16;

endpackage

// File: rtl/trig_pulse_stretch.sv
// Stretches a one-cycle load event into a pulse of programmable width.
// A load during an active pulse reloads the width, so overlapping events
// merge into a single longer high period with no gap.
module trig_pulse_stretch
  import dac_trig_pkg::*;
#(
  parameter int PW_W = DEF_PW_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [PW_W-1:0] i_width,
  output logic            o_pulse
);

  localparam logic [PW_W-1:0] PW_ONE = 1;

  logic [PW_W-1:0] r_remain;
  logic            r_pulse;
  logic [PW_W-1:0] w_width_m1;

  // A width of zero is treated as one cycle, so the remaining count starts at zero
  assign w_width_m1 = (i_width == '0) ? '0 : (i_width - PW_ONE);

  // Pulse goes high the cycle after a load and drops once the remaining count is exhausted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse  <= 1'b0;
      r_remain <= '0;
    end else if (i_load) begin
      r_pulse  <= 1'b1;
      r_remain <= w_width_m1;
    end else if (r_remain != '0) begin
      r_remain <= r_remain - PW_ONE;
    end else begin
      r_pulse  <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/dac_multi_trig_gen.sv
// DAC trigger generator. Each accepted trigger rising edge opens a hold
// window (trig_delay); pulses on dac_multi_trig mark the window's opening
// and/or closing edge as chosen by edge_sel. Also provides retriggering,
// an enable gate, a sticky overrun flag and an accepted-trigger counter.
module dac_multi_trig_gen
  import dac_trig_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PW_W   = DEF_PW_W,
  parameter int TCNT_W = DEF_TCNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              enable,
  input  logic [CNT_W-1:0]  hold_len,
  input  logic [PW_W-1:0]   pulse_width,
  input  logic [1:0]        edge_sel,
  input  logic              retrig_en,
  input  logic              clr_overrun,
  output logic              dac_multi_trig,
  output logic              trig_delay,
  output logic              overrun,
  output logic [TCNT_W-1:0] trig_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [TCNT_W-1:0] TCNT_ONE = 1;

  logic              r_trig_q;
  logic              r_gate;
  logic              r_gate_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_overrun;
  logic [TCNT_W-1:0] r_trig_count;

  logic              w_rise;
  logic              w_accept;
  logic              w_retrig;
  logic              w_overrun_set;
  logic [CNT_W-1:0]  w_hold_m1;
  logic              w_open;
  logic              w_close;
  logic              w_pulse_load;
  logic              w_pulse;

  // Trigger qualification. A rise while the window is open either restarts
  // the window (retrigger) or is dropped and flagged as an overrun; with
  // enable low every rise is silently ignored.
  assign w_rise        = trig & ~r_trig_q;
  assign w_accept      = w_rise & enable & ~r_gate;
  assign w_retrig      = w_rise & enable &  r_gate &  retrig_en;
  assign w_overrun_set = w_rise & enable &  r_gate & ~retrig_en;

  // Zero hold length behaves as a one-cycle window
  assign w_hold_m1 = (hold_len == '0) ? '0 : (hold_len - CNT_ONE);

  // Window edges are seen one cycle after the gate changes, so pulses lag the gate by one more
  assign w_open       = r_gate & ~r_gate_q;
  assign w_close      = ~r_gate & r_gate_q;
  assign w_pulse_load = (w_open & edge_sel[EDGE_OPEN]) | (w_close & edge_sel[EDGE_CLOSE]);

  // Registered copy of trig for edge detection; resets high so a trig held through reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_q <= 1'b1;
    end else begin
      r_trig_q <= trig;
    end
  end

  // Hold window: load the countdown on accept/retrigger, close when it reaches zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept || w_retrig) begin
      r_gate <= 1'b1;
      r_cnt  <= w_hold_m1;
    end else if (r_gate) begin
      if (r_cnt == '0) begin
        r_gate <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // Delayed gate used to find the window's opening and closing edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate_q <= 1'b0;
    end else begin
      r_gate_q <= r_gate;
    end
  end

  // Sticky overrun flag; a new overrun in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  // Counts accepted triggers and accepted retriggers, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_count <= '0;
    end else if (w_accept || w_retrig) begin
      r_trig_count <= r_trig_count + TCNT_ONE;
    end
  end

  trig_pulse_stretch #(
    .PW_W (PW_W)
  ) u_pulse (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_pulse_load),
    .i_width (pulse_width),
    .o_pulse (w_pulse)
  );

  assign dac_multi_trig = w_pulse;
  assign trig_delay     = r_gate;
  assign overrun        = r_overrun;
  assign trig_count     = r_trig_count;

endmodule

// File: tb/tb_dac_multi_trig_gen.sv
// Directed testbench for dac_multi_trig_gen.
// Cycle numbering inside a run: cycle c is the interval right after the
// c-th clock edge of that run; inputs driven in cycle c are sampled at
// the edge that ends it.
module tb_dac_multi_trig_gen;

  logic        clk;
  logic        reset;
  logic        trig;
  logic        enable;
  logic [15:0] hold_len;
  logic [3:0]  pulse_width;
  logic [1:0]  edge_sel;
  logic        retrig_en;
  logic        clr_overrun;
  logic        dac_multi_trig;
  logic        trig_delay;
  logic        overrun;
  logic [15:0] trig_count;

  int checks;
  int failures;

  bit gateLog  [300];
  bit pulseLog [300];
  int logLen;

  dac_multi_trig_gen #(
    .CNT_W  (16),
    .PW_W   (4),
    .TCNT_W (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .trig           (trig),
    .enable         (enable),
    .hold_len       (hold_len),
    .pulse_width    (pulse_width),
    .edge_sel       (edge_sel),
    .retrig_en      (retrig_en),
    .clr_overrun    (clr_overrun),
    .dac_multi_trig (dac_multi_trig),
    .trig_delay     (trig_delay),
    .overrun        (overrun),
    .trig_count     (trig_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int countOnes(input bit useGate);
    int n;
    n = 0;
    for (int c = 0; c < logLen; c++) begin
      if (useGate ? gateLog[c] : pulseLog[c]) n++;
    end
    return n;
  endfunction

  function automatic int firstHigh(input bit useGate);
    for (int c = 0; c < logLen; c++) begin
      if (useGate ? gateLog[c] : pulseLog[c]) return c;
    end
    return -1;
  endfunction

  function automatic int lastHigh(input bit useGate);
    int last;
    last = -1;
    for (int c = 0; c < logLen; c++) begin
      if (useGate ? gateLog[c] : pulseLog[c]) last = c;
    end
    return last;
  endfunction

  // Runs n cycles, logging outputs; trig is high in cycles [t1s..t1e] and [t2s..t2e], clr_overrun in cycle clrCyc
  task automatic runWindow(input int n, input int t1s, input int t1e,
                           input int t2s, input int t2e, input int clrCyc);
    for (int c = 0; c < n; c++) begin
      gateLog[c]  = trig_delay;
      pulseLog[c] = dac_multi_trig;
      trig        = ((c >= t1s) && (c <= t1e)) || ((c >= t2s) && (c <= t2e));
      clr_overrun = (c == clrCyc);
      @(posedge clk); #1;
    end
    trig        = 1'b0;
    clr_overrun = 1'b0;
    logLen      = n;
  endtask

  // Pulses reset with trig low, then lets one idle cycle pass so the trig register settles low
  task automatic doReset();
    trig        = 1'b0;
    clr_overrun = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    trig        = 1'b1;
    enable      = 1'b1;
    hold_len    = 16'd5;
    pulse_width = 4'd1;
    edge_sel    = 2'b11;
    retrig_en   = 1'b0;
    clr_overrun = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (trig_delay !== 1'b0) begin failures++; $display("[TB] FAIL reset_trig_delay: got %b expected 0", trig_delay); end
    checks++;
    if (dac_multi_trig !== 1'b0) begin failures++; $display("[TB] FAIL reset_dac_multi_trig: got %b expected 0", dac_multi_trig); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++;
    if (trig_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_trig_count: got %0d expected 0", trig_count); end
    // trig held high across release must not count as a rising edge
    reset = 1'b0;
    runWindow(10, 0, 9, -1, -2, -1);
    checks++;
    if (countOnes(1'b1) !== 0) begin failures++; $display("[TB] FAIL reset_held_trig_gate: got %0d gate cycles expected 0", countOnes(1'b1)); end
    checks++;
    if (trig_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_held_trig_count: got %0d expected 0", trig_count); end
  endtask

  task automatic test_basic_double_pulse();
    doReset();
    hold_len = 16'd200; pulse_width = 4'd1; edge_sel = 2'b11; retrig_en = 1'b0; enable = 1'b1;
    runWindow(260, 10, 14, -1, -2, -1);
    checks++;
    if (firstHigh(1'b1) !== 11) begin failures++; $display("[TB] FAIL basic_gate_first: got %0d expected 11", firstHigh(1'b1)); end
    checks++;
    if (lastHigh(1'b1) !== 210) begin failures++; $display("[TB] FAIL basic_gate_last: got %0d expected 210", lastHigh(1'b1)); end
    checks++;
    if (countOnes(1'b1) !== 200) begin failures++; $display("[TB] FAIL basic_gate_len: got %0d expected 200", countOnes(1'b1)); end
    checks++;
    if (pulseLog[12] !== 1'b1) begin failures++; $display("[TB] FAIL basic_open_pulse: got %b at cycle 12 expected 1", pulseLog[12]); end
    checks++;
    if (pulseLog[212] !== 1'b1) begin failures++; $display("[TB] FAIL basic_close_pulse: got %b at cycle 212 expected 1", pulseLog[212]); end
    checks++;
    if (countOnes(1'b0) !== 2) begin failures++; $display("[TB] FAIL basic_pulse_count: got %0d pulse cycles expected 2", countOnes(1'b0)); end
    checks++;
    if (trig_count !== 16'd1) begin failures++; $display("[TB] FAIL basic_trig_count: got %0d expected 1", trig_count); end
  endtask

  task automatic test_edge_width();
    doReset();
    hold_len = 16'd20; pulse_width = 4'd3; edge_sel = 2'b10; retrig_en = 1'b0; enable = 1'b1;
    runWindow(40, 5, 6, -1, -2, -1);
    checks++;
    if (lastHigh(1'b1) !== 25) begin failures++; $display("[TB] FAIL edge_gate_last: got %0d expected 25", lastHigh(1'b1)); end
    checks++;
    if (firstHigh(1'b0) !== 27) begin failures++; $display("[TB] FAIL edge_pulse_first: got %0d expected 27", firstHigh(1'b0)); end
    checks++;
    if (lastHigh(1'b0) !== 29) begin failures++; $display("[TB] FAIL edge_pulse_last: got %0d expected 29", lastHigh(1'b0)); end
    checks++;
    if (countOnes(1'b0) !== 3) begin failures++; $display("[TB] FAIL edge_pulse_count: got %0d expected 3", countOnes(1'b0)); end
  endtask

  task automatic test_retrigger();
    doReset();
    hold_len = 16'd50; pulse_width = 4'd1; edge_sel = 2'b11; retrig_en = 1'b1; enable = 1'b1;
    runWindow(100, 5, 6, 35, 36, -1);
    checks++;
    if (firstHigh(1'b1) !== 6) begin failures++; $display("[TB] FAIL retrig_gate_first: got %0d expected 6", firstHigh(1'b1)); end
    checks++;
    if (lastHigh(1'b1) !== 85) begin failures++; $display("[TB] FAIL retrig_gate_last: got %0d expected 85", lastHigh(1'b1)); end
    checks++;
    if (countOnes(1'b1) !== 80) begin failures++; $display("[TB] FAIL retrig_gate_len: got %0d expected 80", countOnes(1'b1)); end
    checks++;
    if ((pulseLog[7] !== 1'b1) || (pulseLog[87] !== 1'b1) || (countOnes(1'b0) !== 2)) begin
      failures++;
      $display("[TB] FAIL retrig_pulses: got open=%b close=%b count=%0d expected 1 1 2", pulseLog[7], pulseLog[87], countOnes(1'b0));
    end
    checks++;
    if (trig_count !== 16'd2) begin failures++; $display("[TB] FAIL retrig_trig_count: got %0d expected 2", trig_count); end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL retrig_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_no_retrigger();
    doReset();
    hold_len = 16'd50; pulse_width = 4'd1; edge_sel = 2'b11; retrig_en = 1'b0; enable = 1'b1;
    runWindow(80, 5, 6, 35, 36, -1);
    checks++;
    if ((firstHigh(1'b1) !== 6) || (lastHigh(1'b1) !== 55)) begin
      failures++;
      $display("[TB] FAIL noretrig_gate_span: got %0d..%0d expected 6..55", firstHigh(1'b1), lastHigh(1'b1));
    end
    checks++;
    if (countOnes(1'b1) !== 50) begin failures++; $display("[TB] FAIL noretrig_gate_len: got %0d expected 50", countOnes(1'b1)); end
    checks++;
    if ((pulseLog[7] !== 1'b1) || (pulseLog[57] !== 1'b1) || (countOnes(1'b0) !== 2)) begin
      failures++;
      $display("[TB] FAIL noretrig_pulses: got open=%b close=%b count=%0d expected 1 1 2", pulseLog[7], pulseLog[57], countOnes(1'b0));
    end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL noretrig_overrun_set: got %b expected 1", overrun); end
    checks++;
    if (trig_count !== 16'd1) begin failures++; $display("[TB] FAIL noretrig_trig_count: got %0d expected 1", trig_count); end
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL overrun_clear: got %b expected 0", overrun); end
    // clear coincides with the ignored rise: the set must win
    runWindow(80, 5, 6, 35, 36, 35);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set_wins: got %b expected 1", overrun); end
    checks++;
    if (trig_count !== 16'd2) begin failures++; $display("[TB] FAIL noretrig_trig_count2: got %0d expected 2", trig_count); end
  endtask

  task automatic test_boundaries();
    doReset();
    hold_len = 16'd0; pulse_width = 4'd1; edge_sel = 2'b11; retrig_en = 1'b0; enable = 1'b1;
    runWindow(20, 5, 6, -1, -2, -1);
    checks++;
    if ((countOnes(1'b1) !== 1) || (firstHigh(1'b1) !== 6)) begin
      failures++;
      $display("[TB] FAIL hold0_gate: got len=%0d first=%0d expected len=1 first=6", countOnes(1'b1), firstHigh(1'b1));
    end
    checks++;
    if ((countOnes(1'b0) !== 2) || (firstHigh(1'b0) !== 7) || (lastHigh(1'b0) !== 8)) begin
      failures++;
      $display("[TB] FAIL hold0_pulse: got %0d..%0d count=%0d expected 7..8 count=2", firstHigh(1'b0), lastHigh(1'b0), countOnes(1'b0));
    end
    hold_len = 16'd2; pulse_width = 4'd4;
    runWindow(25, 5, 6, -1, -2, -1);
    checks++;
    if (countOnes(1'b1) !== 2) begin failures++; $display("[TB] FAIL hold2_gate_len: got %0d expected 2", countOnes(1'b1)); end
    checks++;
    if ((firstHigh(1'b0) !== 7) || (lastHigh(1'b0) !== 12) || (countOnes(1'b0) !== 6)) begin
      failures++;
      $display("[TB] FAIL merge_pulse: got %0d..%0d count=%0d expected 7..12 count=6", firstHigh(1'b0), lastHigh(1'b0), countOnes(1'b0));
    end
    doReset();
    enable = 1'b0; hold_len = 16'd10; pulse_width = 4'd1;
    runWindow(30, 5, 6, -1, -2, -1);
    checks++;
    if ((countOnes(1'b1) !== 0) || (countOnes(1'b0) !== 0)) begin
      failures++;
      $display("[TB] FAIL disabled_activity: got gate=%0d pulse=%0d expected 0 0", countOnes(1'b1), countOnes(1'b0));
    end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL disabled_overrun: got %b expected 0", overrun); end
    checks++;
    if (trig_count !== 16'd0) begin failures++; $display("[TB] FAIL disabled_trig_count: got %0d expected 0", trig_count); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_window();
    doReset();
    hold_len = 16'd50; pulse_width = 4'd15; edge_sel = 2'b11; retrig_en = 1'b0; enable = 1'b1;
    runWindow(16, 5, 15, -1, -2, -1);
    trig = 1'b1;
    checks++;
    if ((trig_delay !== 1'b1) || (dac_multi_trig !== 1'b1) || (trig_count !== 16'd1)) begin
      failures++;
      $display("[TB] FAIL midreset_pre: got gate=%b pulse=%b count=%0d expected 1 1 1", trig_delay, dac_multi_trig, trig_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (trig_delay !== 1'b0) begin failures++; $display("[TB] FAIL midreset_trig_delay: got %b expected 0", trig_delay); end
    checks++;
    if (dac_multi_trig !== 1'b0) begin failures++; $display("[TB] FAIL midreset_dac_multi_trig: got %b expected 0", dac_multi_trig); end
    checks++;
    if (trig_count !== 16'd0) begin failures++; $display("[TB] FAIL midreset_trig_count: got %0d expected 0", trig_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    runWindow(20, 0, 19, -1, -2, -1);
    checks++;
    if ((countOnes(1'b1) !== 0) || (countOnes(1'b0) !== 0)) begin
      failures++;
      $display("[TB] FAIL midreset_after: got gate=%0d pulse=%0d expected 0 0", countOnes(1'b1), countOnes(1'b0));
    end
    checks++;
    if (trig_count !== 16'd0) begin failures++; $display("[TB] FAIL midreset_after_count: got %0d expected 0", trig_count); end
  endtask

  // Test sequence
  initial begin
    checks   = 0;
    failures = 0;
    logLen   = 0;
    test_reset();
    test_basic_double_pulse();
    test_edge_width();
    test_retrigger();
    test_no_retrigger();
    test_boundaries();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
